block_renderer: RTL
===================

# block_renderer

Parametrised successor to the single-rectangle VGA colouring logic. Holds NUM_BLOCKS movable, individually coloured rectangles and accepts move/recolour commands through a valid/ready handshake (keyboard decoder upstream). Commits position changes only at frame boundaries, so frames never tear. Produces registered R/G/B for the pixel position supplied by the sync generator, in 640x480 or 800x600 mode.

## Interface
- NUM_BLOCKS, 4: number of rectangles, 1..8
- COLOR_W, 4: bits per colour channel
- COORD_W, 11: width of xpos/ypos and position registers
- BLK_W, 64: rectangle width in pixels
- BLK_H, 48: rectangle height in pixels
- STEP, 8: pixels moved per command
- SEL_W, $clog2(NUM_BLOCKS) (min 1): block-select width

Ports:
- clk  in  1  pixel clock
- rst  in  1  synchronous, active-low reset
- mode  in  1  0 = 640x480, 1 = 800x600; sampled at frame_start only
- frame_start  in  1  one-cycle pulse, first cycle of vertical blanking
- xpos, ypos  in  COORD_W  current pixel coordinate
- disp_active  in  1  pixel is in the visible area
- cmd_valid  in  1  command offered
- cmd_ready  out  1  command register empty
- cmd_sel  in  SEL_W  target block
- cmd_op  in  3  0 up, 1 down, 2 left, 3 right, 4 set colour, 5-7 no-op
- cmd_color  in  3*COLOR_W  {R,G,B} for op 4
- R, G, B  out  COLOR_W  registered pixel colour

## Operation
- Block k registers: x_k, y_k (COORD_W), col_k (3*COLOR_W). Reset: x_k = k*(BLK_W+16), y_k = 0, col_k = {all ones, k, ~k}, each field truncated to COLOR_W. Reset also sets R/G/B = 0, cmd_ready = 1, FSM = IDLE, held = 0, active resolution = 640x480.
- Handshake: transfer when cmd_valid && cmd_ready. Sel/op/colour latch into a one-entry register; held = 1, cmd_ready = !held. cmd_sel >= NUM_BLOCKS is accepted and discarded at apply time.
- FSM: IDLE -> SWEEP on frame_start. SWEEP latches mode into the active resolution (hres, vres) on entry. It visits idx = 0..NUM_BLOCKS-1, one per cycle, clamping x_idx to hres-BLK_W and y_idx to vres-BLK_H. After the last index it goes to APPLY if held, else IDLE. APPLY lasts one cycle, executes the held command, clears held, then returns to IDLE.
- Move arithmetic uses COORD_W+1 bits:
  - up/left: if coord < STEP, result is 0, else coord - STEP.
  - down/right: if coord + STEP > limit, result is limit, else coord + STEP.
  - limits are vres-BLK_H and hres-BLK_W.
- Set colour: col_sel <= cmd_color.
- Hit test for block k: x_k <= xpos < x_k+BLK_W and y_k <= ypos < y_k+BLK_H. Edges are inclusive left/top, exclusive right/bottom.
- Overlap: lowest index wins.
- Colour output: pixel = col of the winning block, else 0. If disp_active = 0, pixel = 0; outputs are never high-Z.
- frame_start outside IDLE is ignored.
- A command accepted in the same cycle as frame_start is applied at the following frame_start, not the current one.

## Timing
- Pixel path latency is 1 cycle: R/G/B at cycle t+1 reflect xpos/ypos/disp_active at cycle t.
- Command latency: cmd_ready falls the cycle after acceptance. It rises the cycle after APPLY, which is NUM_BLOCKS+2 cycles after the next frame_start (IDLE→SWEEP, N sweep cycles, APPLY).
- Positions change only during SWEEP/APPLY. This is within vertical blanking by construction, because blanking is far longer than NUM_BLOCKS+2 cycles.
- Reset mid-operation: the pending command is discarded, the sweep is aborted, and all state returns to reset values on the next edge.

## Structure
- Shared package: resolution constants (640/480, 800/600), cmd_op encodings, and FSM state enum (IDLE, SWEEP, APPLY).
- Sub-module block_hit: per-block comparator giving hit from (xpos, ypos, x_k, y_k), instantiated NUM_BLOCKS times.
- Priority mux, FSM, and register file stay in the top.

## Test plan
- Reset, mode 0, pixel (5,5) with disp_active = 1 -> next cycle R = 4'hF, G = 0, B = 4'hF (block 0). Pixel (64,5) -> 0 (exclusive right edge).
- Command sel 1, op right, then frame_start -> x_1 goes from 80 to 88 at APPLY. cmd_ready is low from acceptance until APPLY+1.
- Block 0 at x = 3, command left -> x_0 = 0. Block 0 at x = 570 in mode 0, command right -> x_0 = 576.
- Mode 1 with x_2 = 700, switch to mode 0, frame_start -> SWEEP clamps x_2 to 576 before APPLY.
- Blocks 0 and 1 overlapping at (100,10) -> block 0 colour is output. disp_active = 0 at the same point -> 0.
- Command accepted in the same cycle as frame_start -> no position change this frame, applied next frame. rst low during SWEEP -> positions return to reset values and held = 0.

Source files
------------

// File: rtl/block_renderer_pkg.sv
// Shared definitions for the block renderer: screen resolutions,
// command opcodes and the commit state machine encoding.
package block_renderer_pkg;

   // Visible area sizes for the two supported video modes
   localparam int H_RES_640 = 640;
   localparam int V_RES_480 = 480;
   localparam int H_RES_800 = 800;
   localparam int V_RES_600 = 600;

   // Command opcodes delivered by the keyboard decoder; 5..7 do nothing
   localparam logic [2:0] OP_UP     = 3'd0;
   localparam logic [2:0] OP_DOWN   = 3'd1;
   localparam logic [2:0] OP_LEFT   = 3'd2;
   localparam logic [2:0] OP_RIGHT  = 3'd3;
   localparam logic [2:0] OP_SETCOL = 3'd4;

   // Commit FSM: wait for a frame, clamp every block, then apply one command
   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SWEEP,
      ST_APPLY
   } state_t;

endpackage

// File: rtl/block_hit.sv
// Per-block rectangle comparator. Left/top edges are inclusive and
// right/bottom edges exclusive; sums are widened by one bit so a block
// near the top of the coordinate range cannot wrap.
module block_hit #(
   parameter int COORD_W = 11,
   parameter int BLK_W   = 64,
   parameter int BLK_H   = 48
) (
   input  logic [COORD_W-1:0] i_xpos,
   input  logic [COORD_W-1:0] i_ypos,
   input  logic [COORD_W-1:0] i_blkX,
   input  logic [COORD_W-1:0] i_blkY,
   output logic               o_hit
);

   localparam int EW = COORD_W + 1;

   logic [EW-1:0] w_xEnd;
   logic [EW-1:0] w_yEnd;

   assign w_xEnd = {1'b0, i_blkX} + EW'(BLK_W);
   assign w_yEnd = {1'b0, i_blkY} + EW'(BLK_H);

   assign o_hit = (i_xpos >= i_blkX) && ({1'b0, i_xpos} < w_xEnd) &&
                  (i_ypos >= i_blkY) && ({1'b0, i_ypos} < w_yEnd);

endmodule

// File: rtl/block_renderer.sv
// Multi-rectangle renderer. Holds NUM_BLOCKS movable coloured blocks,
// buffers one command at a time, and only touches block positions in the
// short SWEEP/APPLY window that starts at frame_start, so a frame never
// shows a half-moved block.
module block_renderer
   import block_renderer_pkg::*;
#(
   parameter int NUM_BLOCKS = 4,
   parameter int COLOR_W    = 4,
   parameter int COORD_W    = 11,
   parameter int BLK_W      = 64,
   parameter int BLK_H      = 48,
   parameter int STEP       = 8,
   parameter int SEL_W      = (NUM_BLOCKS > 1) ? $clog2(NUM_BLOCKS) : 1
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   mode,
   input  logic                   frame_start,
   input  logic [COORD_W-1:0]     xpos,
   input  logic [COORD_W-1:0]     ypos,
   input  logic                   disp_active,
   input  logic                   cmd_valid,
   output logic                   cmd_ready,
   input  logic [SEL_W-1:0]       cmd_sel,
   input  logic [2:0]             cmd_op,
   input  logic [3*COLOR_W-1:0]   cmd_color,
   output logic [COLOR_W-1:0]     R,
   output logic [COLOR_W-1:0]     G,
   output logic [COLOR_W-1:0]     B
);

   localparam int CW = 3 * COLOR_W;
   localparam int EW = COORD_W + 1;

   logic [COORD_W-1:0] r_x   [NUM_BLOCKS];
   logic [COORD_W-1:0] r_y   [NUM_BLOCKS];
   logic [CW-1:0]      r_col [NUM_BLOCKS];

   state_t             r_state;
   logic [SEL_W-1:0]   r_idx;
   logic               r_held;
   logic               r_armed;
   logic [SEL_W-1:0]   r_cmdSel;
   logic [2:0]         r_cmdOp;
   logic [CW-1:0]      r_cmdColor;
   logic [COORD_W-1:0] r_hres;
   logic [COORD_W-1:0] r_vres;
   logic [CW-1:0]      r_pix;

   logic [COORD_W-1:0]    w_limX;
   logic [COORD_W-1:0]    w_limY;
   logic                  w_selValid;
   logic [COORD_W-1:0]    w_curX;
   logic [COORD_W-1:0]    w_curY;
   logic [COORD_W-1:0]    w_newX;
   logic [COORD_W-1:0]    w_newY;
   logic [NUM_BLOCKS-1:0] w_hit;
   logic [CW-1:0]         w_pixNext;

   // Step toward zero, stopping at zero instead of wrapping
   function automatic logic [COORD_W-1:0] decStep(input logic [COORD_W-1:0] c);
      logic [EW-1:0] e;
      e = {1'b0, c};
      if (e < EW'(STEP)) decStep = '0;
      else               decStep = COORD_W'(e - EW'(STEP));
   endfunction

   // Step away from zero, stopping at the edge limit for the active mode
   function automatic logic [COORD_W-1:0] incStep(input logic [COORD_W-1:0] c,
                                                  input logic [COORD_W-1:0] lim);
      logic [EW-1:0] e;
      e = {1'b0, c} + EW'(STEP);
      if (e > {1'b0, lim}) incStep = lim;
      else                 incStep = e[COORD_W-1:0];
   endfunction

   assign w_limX     = r_hres - COORD_W'(BLK_W);
   assign w_limY     = r_vres - COORD_W'(BLK_H);
   assign w_selValid = (32'(r_cmdSel) < NUM_BLOCKS);
   assign w_curX     = r_x[r_cmdSel];
   assign w_curY     = r_y[r_cmdSel];
   assign cmd_ready  = ~r_held;

   // Position the held command would produce for its target block
   always_comb begin
      w_newX = w_curX;
      w_newY = w_curY;
      case (r_cmdOp)
         OP_UP:    w_newY = decStep(w_curY);
         OP_DOWN:  w_newY = incStep(w_curY, w_limY);
         OP_LEFT:  w_newX = decStep(w_curX);
         OP_RIGHT: w_newX = incStep(w_curX, w_limX);
         default:  ;
      endcase
   end

   // Commit FSM plus block register file; the armed flag snapshots whether a
   // command was already waiting when the frame began, so a command that
   // arrives with frame_start waits for the next frame
   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int k = 0; k < NUM_BLOCKS; k++) begin
            r_x[k]   <= COORD_W'(k * (BLK_W + 16));
            r_y[k]   <= '0;
            r_col[k] <= {{COLOR_W{1'b1}}, COLOR_W'(k), ~COLOR_W'(k)};
         end
         r_state    <= ST_IDLE;
         r_idx      <= '0;
         r_held     <= 1'b0;
         r_armed    <= 1'b0;
         r_cmdSel   <= '0;
         r_cmdOp    <= 3'd7;
         r_cmdColor <= '0;
         r_hres     <= COORD_W'(H_RES_640);
         r_vres     <= COORD_W'(V_RES_480);
      end else begin
         if (cmd_valid && !r_held) begin
            r_held     <= 1'b1;
            r_cmdSel   <= cmd_sel;
            r_cmdOp    <= cmd_op;
            r_cmdColor <= cmd_color;
         end
         case (r_state)
            ST_IDLE: begin
               if (frame_start) begin
                  r_state <= ST_SWEEP;
                  r_idx   <= '0;
                  r_armed <= r_held;
                  r_hres  <= mode ? COORD_W'(H_RES_800) : COORD_W'(H_RES_640);
                  r_vres  <= mode ? COORD_W'(V_RES_600) : COORD_W'(V_RES_480);
               end
            end
            ST_SWEEP: begin
               if (r_x[r_idx] > w_limX) r_x[r_idx] <= w_limX;
               if (r_y[r_idx] > w_limY) r_y[r_idx] <= w_limY;
               if (r_idx == SEL_W'(NUM_BLOCKS - 1)) begin
                  r_state <= r_armed ? ST_APPLY : ST_IDLE;
               end else begin
                  r_idx <= r_idx + SEL_W'(1);
               end
            end
            ST_APPLY: begin
               if (w_selValid) begin
                  r_x[r_cmdSel] <= w_newX;
                  r_y[r_cmdSel] <= w_newY;
                  if (r_cmdOp == OP_SETCOL) r_col[r_cmdSel] <= r_cmdColor;
               end
               r_held  <= 1'b0;
               r_armed <= 1'b0;
               r_state <= ST_IDLE;
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   for (genvar g = 0; g < NUM_BLOCKS; g++) begin : g_hit
      block_hit #(
         .COORD_W (COORD_W),
         .BLK_W   (BLK_W),
         .BLK_H   (BLK_H)
      ) u_hit (
         .i_xpos (xpos),
         .i_ypos (ypos),
         .i_blkX (r_x[g]),
         .i_blkY (r_y[g]),
         .o_hit  (w_hit[g])
      );
   end

   // Priority mux: scanning from the top index down lets the lowest hit win
   always_comb begin
      w_pixNext = '0;
      for (int k = NUM_BLOCKS - 1; k >= 0; k--) begin
         if (w_hit[k]) w_pixNext = r_col[k];
      end
      if (!disp_active) w_pixNext = '0;
   end

   // Register the pixel colour so R/G/B trail the coordinate by one clock
   always_ff @(posedge clk) begin
      if (!rst) r_pix <= '0;
      else      r_pix <= w_pixNext;
   end

   assign R = r_pix[CW-1 -: COLOR_W];
   assign G = r_pix[2*COLOR_W-1 -: COLOR_W];
   assign B = r_pix[COLOR_W-1 -: COLOR_W];

endmodule
